// File: rtl/jtag_pkg.sv
// Shared types and TAP walk constants for the JTAG scan master.
package jtag_pkg;

  typedef enum logic [1:0] {
    CMD_RESET    = 2'd0,
    CMD_SCAN_IR  = 2'd1,
    CMD_SCAN_DR  = 2'd2,
    CMD_RUN_IDLE = 2'd3
  } jtag_cmd_t;

  typedef enum logic [2:0] {
    IDLE, TLR_SEQ, PRE, SHIFT, POST, RTI_CYC, RESP
  } scan_master_st_t;

  // IEEE 1149.1 controller states, for any debug model of the target TAP
  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PAU_DR, TAP_EX2_DR,
    TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PAU_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_ctrl_fsm_t;

  localparam int TLR_TMS_CYCLES = 5;
  localparam int IR_PRE_LEN     = 4;
  localparam int DR_PRE_LEN     = 3;
  localparam int POST_LEN       = 2;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV clk cycles low then CLK_DIV high, with edge strobes.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck_o,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  // Strobes are high in the cycle whose closing edge toggles tck_o
  assign wrap       = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_pulse = wrap && !tck_o;
  assign fall_pulse = wrap && tck_o;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      tck_o <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      tck_o <= !tck_o;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Command-driven JTAG TAP sequencer; every walk starts and ends in Run-Test/Idle.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_type,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                tck_o,
  output logic                tms_o,
  output logic                tdi_o,
  input  logic                tdo_i,
  output logic                busy
);

  scan_master_st_t     state, state_n;
  jtag_cmd_t           op, op_n;
  logic [LEN_W-1:0]    len, len_n, cnt, cnt_n;
  logic [MAX_BITS-1:0] data, data_n, cap, cap_n;
  logic                tms, tms_n, tdi, tdi_n, synced, synced_n;
  logic                rise, fall;

  assign busy      = (state != IDLE) && (state != RESP);
  assign rsp_valid = (state == RESP);
  assign cmd_ready = !busy && !rsp_valid;
  assign rsp_data  = cap;
  assign tms_o     = tms;
  assign tdi_o     = tdi;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk(clk), .rst(rst), .en(busy), .tck_o(tck_o), .rise_pulse(rise), .fall_pulse(fall)
  );

  function automatic int pre_len(jtag_cmd_t o);
    return (o == CMD_SCAN_IR) ? IR_PRE_LEN : DR_PRE_LEN;
  endfunction

  // Phase that follows the TAP reset prefix (or starts directly when synced)
  function automatic scan_master_st_t body_st(jtag_cmd_t o, logic [LEN_W-1:0] l);
    case (o)
      CMD_RESET:    return RESP;
      CMD_RUN_IDLE: return (l == '0) ? RESP : RTI_CYC;
      default:      return PRE;
    endcase
  endfunction

  function automatic scan_master_st_t next_st(scan_master_st_t s, jtag_cmd_t o,
                                              logic [LEN_W-1:0] l);
    case (s)
      TLR_SEQ: return body_st(o, l);
      PRE:     return SHIFT;
      SHIFT:   return POST;
      default: return RESP;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] last_cnt(scan_master_st_t s, jtag_cmd_t o,
                                                logic [LEN_W-1:0] l);
    case (s)
      TLR_SEQ:        return LEN_W'(TLR_TMS_CYCLES);
      PRE:            return LEN_W'(pre_len(o) - 1);
      SHIFT, RTI_CYC: return l - 1'b1;
      POST:           return LEN_W'(POST_LEN - 1);
      default:        return '0;
    endcase
  endfunction

  // {tms, tdi} for step c of phase s
  function automatic logic [1:0] drive(scan_master_st_t s, logic [LEN_W-1:0] c, jtag_cmd_t o,
                                       logic [LEN_W-1:0] l, logic [MAX_BITS-1:0] d);
    logic [MAX_BITS-1:0] sh;
    sh = d >> c;
    case (s)
      TLR_SEQ: return {c < LEN_W'(TLR_TMS_CYCLES), 1'b0};
      PRE:     return {c < LEN_W'(pre_len(o) - 2), 1'b0};
      SHIFT:   return {c == l - 1'b1, sh[0]};
      POST:    return {c == '0, 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    op_n     = op;
    len_n    = len;
    data_n   = data;
    cap_n    = cap;
    cnt_n    = cnt;
    tms_n    = tms;
    tdi_n    = tdi;
    synced_n = synced;
    case (state)
      IDLE: if (cmd_valid) begin
        op_n   = jtag_cmd_t'(cmd_type);
        len_n  = cmd_len;
        if (op_n != CMD_RUN_IDLE) begin
          if (cmd_len == '0) len_n = LEN_W'(1);
          else if (cmd_len > LEN_W'(MAX_BITS)) len_n = LEN_W'(MAX_BITS);
        end
        data_n  = cmd_data;
        cap_n   = '0;
        cnt_n   = '0;
        state_n = (op_n == CMD_RESET || !synced) ? TLR_SEQ : body_st(op_n, len_n);
        {tms_n, tdi_n} = drive(state_n, '0, op_n, len_n, data_n);
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: begin
        if (rise && state == SHIFT) cap_n = cap | (MAX_BITS'(tdo_i) << cnt);
        if (fall) begin
          if (cnt == last_cnt(state, op, len)) begin
            if (state == TLR_SEQ) synced_n = 1'b1;
            state_n = next_st(state, op, len);
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
          {tms_n, tdi_n} = drive(state_n, cnt_n, op, len, data);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= CMD_RESET;
      len    <= '0;
      data   <= '0;
      cap    <= '0;
      cnt    <= '0;
      tms    <= 1'b1;
      tdi    <= 1'b0;
      synced <= 1'b0;
    end else begin
      state  <= state_n;
      op     <= op_n;
      len    <= len_n;
      data   <= data_n;
      cap    <= cap_n;
      cnt    <= cnt_n;
      tms    <= tms_n;
      tdi    <= tdi_n;
      synced <= synced_n;
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural target TAP (4-bit IR, IDCODE DR).
module tb_jtag_scan_master;

  localparam int MB = 64;
  localparam int LW = 7;

  logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0]    cmd_type = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [MB-1:0] cmd_data = '0;
  logic          cmd_ready, rsp_valid, tck_o, tms_o, tdi_o, tdo_i, busy;
  logic [MB-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  jtag_scan_master #(.CLK_DIV(2), .MAX_BITS(MB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- target TAP model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR,
    T_UPDDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPDIR
  } tap_t;

  tap_t          tap = T_TLR;
  logic [3:0]    ir = 4'h2, ir_sr = 4'h0;
  logic [31:0]   dr_sr = 32'h0;
  int            rises = 0, per4 = 0, last_rise = 0;
  logic [127:0]  tms_log = '0;

  function automatic tap_t tap_next(tap_t s, logic t);
    case (s)
      T_TLR:           return t ? T_TLR   : T_RTI;
      T_RTI:           return t ? T_SELDR : T_RTI;
      T_SELDR:         return t ? T_SELIR : T_CAPDR;
      T_CAPDR, T_SHDR: return t ? T_EX1DR : T_SHDR;
      T_EX1DR:         return t ? T_UPDDR : T_PAUDR;
      T_PAUDR:         return t ? T_EX2DR : T_PAUDR;
      T_EX2DR:         return t ? T_UPDDR : T_SHDR;
      T_UPDDR, T_UPDIR:return t ? T_SELDR : T_RTI;
      T_SELIR:         return t ? T_TLR   : T_CAPIR;
      T_CAPIR, T_SHIR: return t ? T_EX1IR : T_SHIR;
      T_EX1IR:         return t ? T_UPDIR : T_PAUIR;
      T_PAUIR:         return t ? T_EX2IR : T_PAUIR;
      T_EX2IR:         return t ? T_UPDIR : T_SHIR;
      default:         return T_TLR;
    endcase
  endfunction

  assign tdo_i = (tap == T_SHIR) ? ir_sr[0] : (tap == T_SHDR) ? dr_sr[0] : 1'b0;

  always @(posedge tck_o) begin
    rises   <= rises + 1;
    tms_log <= {tms_log[126:0], tms_o};
    if (cyc - last_rise == 4) per4 <= per4 + 1;
    last_rise <= cyc;
    case (tap)
      T_TLR:   ir    <= 4'h2;
      T_CAPIR: ir_sr <= 4'b0001;
      T_SHIR:  ir_sr <= {tdi_o, ir_sr[3:1]};
      T_UPDIR: ir    <= ir_sr;
      T_CAPDR: dr_sr <= (ir == 4'h2) ? 32'hDEADBEEF : 32'h0;
      T_SHDR:  dr_sr <= {tdi_o, dr_sr[31:1]};
      default: ;
    endcase
    tap <= tap_next(tap, tms_o);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command, scrambles the inputs after acceptance, waits for and consumes the response
  task automatic run_cmd(input logic [1:0] ty, input logic [LW-1:0] ln, input logic [MB-1:0] d,
                         output logic [MB-1:0] rsp, output int ntck, output int lat,
                         output logic to);
    int r0, n;
    to = 1'b0;
    rsp = '0;
    @(negedge clk);
    cmd_type = ty; cmd_len = ln; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) to = 1'b1;
    r0 = rises;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_type = ~ty; cmd_len = ~ln; cmd_data = ~d;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    if (!rsp_valid) to = 1'b1;
    lat  = n;
    rsp  = rsp_data;
    ntck = rises - r0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [MB-1:0] rsp;
    int ntck, lat, p0, r0, n, bad;
    logic to;

    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({tck_o, tms_o, tdi_o, cmd_ready, rsp_valid, busy}), 64'b010100);
    chk("reset_rsp_data", rsp_data, 64'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // RESET: 6 TCKs, TMS 1,1,1,1,1,0, period 4 clk
    p0 = per4;
    run_cmd(2'd0, 7'd0, 64'h0, rsp, ntck, lat, to);
    chk("reset_timeout", 64'(to), 64'h0);
    chk("reset_ntck", 64'(ntck), 64'd6);
    chk("reset_tms", 64'(tms_log[5:0]), 64'b111110);
    chk("reset_rsp", rsp, 64'h0);
    chk("reset_period", 64'(per4 - p0), 64'd5);
    chk("reset_latency", 64'(lat), 64'd24);
    chk("reset_tap_rti", 64'(tap), 64'(T_RTI));

    // SCAN_IR 4 bits of 0x2
    run_cmd(2'd1, 7'd4, 64'h2, rsp, ntck, lat, to);
    chk("ir_timeout", 64'(to), 64'h0);
    chk("ir_ntck", 64'(ntck), 64'd10);
    chk("ir_tms", 64'(tms_log[9:0]), 64'b1100000110);
    chk("ir_rsp", rsp, 64'h1);
    chk("ir_decoded", 64'(ir), 64'h2);
    chk("ir_tap_rti", 64'(tap), 64'(T_RTI));

    // SCAN_DR 32 reads IDCODE
    run_cmd(2'd2, 7'd32, 64'h0, rsp, ntck, lat, to);
    chk("dr32_ntck", 64'(ntck), 64'd37);
    chk("dr32_rsp", rsp, 64'h00000000DEADBEEF);

    // RUN_IDLE 3 and 0
    run_cmd(2'd3, 7'd3, 64'h0, rsp, ntck, lat, to);
    chk("rti3_ntck", 64'(ntck), 64'd3);
    chk("rti3_tms", 64'(tms_log[2:0]), 64'b000);
    chk("rti3_rsp", rsp, 64'h0);
    run_cmd(2'd3, 7'd0, 64'h0, rsp, ntck, lat, to);
    chk("rti0_ntck", 64'(ntck), 64'd0);
    chk("rti0_latency", 64'(lat), 64'd0);

    // First command after rst gets the reset prefix
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cmd(2'd2, 7'd8, 64'h0, rsp, ntck, lat, to);
    chk("prefix_dr8_ntck", 64'(ntck), 64'd19);
    chk("prefix_dr8_rsp", rsp, 64'h00000000000000EF);

    // Response back-pressure with cmd_valid held high
    @(negedge clk);
    cmd_type = 2'd3; cmd_len = 7'd2; cmd_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    chk("stall_rsp_seen", 64'(rsp_valid), 64'h1);
    r0 = rises; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bad++;
    end
    chk("stall_ready_low", 64'(bad), 64'h0);
    chk("stall_no_tck", 64'(rises - r0), 64'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_ready_back", 64'(cmd_ready), 64'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("stall_next_accept", 64'(busy), 64'h1);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Abort with rst during shift bit 10 of a 32-bit DR scan
    @(negedge clk);
    cmd_type = 2'd2; cmd_len = 7'd32; cmd_data = 64'h0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    r0 = rises; n = 0;
    while (rises - r0 < 14 && n < 400) begin @(negedge clk); n++; end
    chk("abort_reached_bit10", 64'(rises - r0), 64'd14);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", 64'({tck_o, tms_o, rsp_valid, busy, cmd_ready}), 64'b01001);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    chk("abort_no_rsp", 64'(bad), 64'h0);
    run_cmd(2'd1, 7'd4, 64'h2, rsp, ntck, lat, to);
    chk("abort_ir_ntck", 64'(ntck), 64'd16);
    chk("abort_ir_tms", 64'(tms_log[15:0]), 64'b1111101100000110);
    chk("abort_ir_rsp", rsp, 64'h1);

    // Length boundaries
    run_cmd(2'd2, 7'd0, 64'h0, rsp, ntck, lat, to);
    chk("len0_ntck", 64'(ntck), 64'd6);
    chk("len0_tms", 64'(tms_log[5:0]), 64'b100110);
    chk("len0_rsp", rsp, 64'h1);
    run_cmd(2'd2, 7'd100, 64'h0123456789ABCDEF, rsp, ntck, lat, to);
    chk("len100_timeout", 64'(to), 64'h0);
    chk("len100_ntck", 64'(ntck), 64'd69);
    chk("len100_rsp", rsp, 64'h89ABCDEFDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
System-clock-side sequencer that drives a JTAG TAP (TCK/TMS/TDI) and captures TDO, turning high-level commands into TAP walks. Supported commands are TAP reset, IR scan, DR scan and Run-Test/Idle cycles. It sits between a host bus bridge and the TAP pins. It keeps an internal model of the TAP state so every scan starts and ends in RUN_TEST_IDLE.

Parameters:
CLK_DIV, 2, clk cycles per TCK half-period (>=1)
MAX_BITS, 64, maximum scan length and data width
LEN_W, 7, width of cmd_len ($clog2(MAX_BITS)+1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both valid and ready are high
cmd_type  in  2  jtag_cmd_t: 0 RESET, 1 SCAN_IR, 2 SCAN_DR, 3 RUN_IDLE
cmd_len  in  LEN_W  bits to shift (scans) or TCK cycles (RUN_IDLE)
cmd_data  in  MAX_BITS  TDI data, bit 0 shifted first
rsp_valid  out  1  response available, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  MAX_BITS  captured TDO; bit i = TDO sampled on shift bit i; upper bits 0
tck_o  out  1  TCK
tms_o  out  1  TMS
tdi_o  out  1  TDI
tdo_i  in  1  TDO from TAP
busy  out  1  command in progress

Behaviour:
- Single clock clk; reset synchronous, active-high on rst.
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0. Reset also clears the internal `synced` flag.
- TCK timing:
  - Each TCK period = 2*CLK_DIV clk cycles: low phase, then high phase.
  - tms_o/tdi_o change only in the clk cycle where tck_o falls (or at walk start while tck_o=0).
  - tdo_i is sampled in the clk cycle where tck_o rises.
  - tck_o idles low between commands.
- Handshake:
  - cmd_ready = !busy && !rsp_valid.
  - A command is accepted on a clk edge with cmd_valid && cmd_ready; busy rises next cycle.
  - Exactly one response per command (RESET/RUN_IDLE return rsp_data=0).
  - rsp_valid rises the cycle after the last TCK high phase ends and holds until rsp_ready.
- Length rules:
  - Scan len 0 is treated as 1; len > MAX_BITS is clamped to MAX_BITS.
  - RUN_IDLE with len 0 completes with zero TCK pulses and responds next cycle.
- FSM states: IDLE, TLR_SEQ, PRE, SHIFT, POST, RTI_CYC, RESP.
  - TLR_SEQ: 5 TCKs with TMS=1, then 1 TCK with TMS=0 (lands in RUN_TEST_IDLE). Sets synced.
  - PRE: IR uses TMS 1,1,0,0; DR uses TMS 1,0,0. Ends in SHIFT_IR/SHIFT_DR.
  - SHIFT: N TCKs, tdi_o = cmd_data[i], TMS=0 except TMS=1 on bit N-1 (to EXIT1).
  - POST: TMS 1 (UPDATE), then TMS 0 (RUN_TEST_IDLE).
  - RTI_CYC: len TCKs with TMS=0.
- TCK counts per command:
  - RESET = 6.
  - SCAN_IR = N+6.
  - SCAN_DR = N+5.
  - RUN_IDLE = len.
  - If !synced, any non-RESET command first runs TLR_SEQ (+6 TCKs).
- rst mid-command aborts immediately: outputs return to reset values, the response is dropped, and synced is cleared.
- Command fields are latched at acceptance; input changes while busy are ignored.

Decomposition:
- jtag_pkg gets:
  - jtag_cmd_t enum
  - scan_master_st_t FSM enum
  - TLR_TMS_CYCLES=5, IR_PRE_LEN=4, DR_PRE_LEN=3 constants
  - reuses tap_ctrl_fsm_t for the optional debug TAP-state model
- Sub-module jtag_tck_gen:
  - counts CLK_DIV, drives tck_o
  - emits one-cycle fall_pulse and rise_pulse strobes; the FSM advances only on these
  - enabled by busy, held low otherwise

Test Plan:
- CLK_DIV=2, RESET after rst -> 6 TCK pulses of period 4 clk, TMS sequence 1,1,1,1,1,0; rsp_valid, rsp_data=0; bench TAP model in RUN_TEST_IDLE.
- SCAN_IR len=4 data=0x2, bench IR captures 0b0001 -> 10 TCKs, TMS 1,1,0,0,0,0,0,1,1,0; rsp_data=0x1; bench IR decodes 0x2.
- SCAN_DR len=32 after selecting IDCODE, bench IDCODE 0xDEADBEEF -> 37 TCKs, rsp_data=0x00000000DEADBEEF.
- First command after rst is SCAN_DR len=8 -> 6-TCK reset prefix, then 13 TCKs (19 total); capture correct.
- rsp_ready held low 20 cycles with cmd_valid high -> cmd_ready=0 throughout, no TCK edges; after rsp_ready, next command accepted the following cycle.
- rst asserted mid-SHIFT (bit 10 of 32) -> next cycle tck_o=0, tms_o=1, no rsp_valid. Next SCAN_IR gets the reset prefix. len=0 scan shifts 1 bit; len=100 clamps to 64.
